// File: rtl/uart_pkg.sv
// Shared types and constants for the 12-bit sample word UART receiver.
// Bit-level and word-level FSM encodings plus the byte tag values.
package uart_pkg;

  localparam logic [1:0] TAG_HI = 2'b10;
  localparam logic [1:0] TAG_LO = 2'b00;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_BREAK
  } bit_st_e;

  typedef enum logic {
    W_HI,
    W_LO
  } word_st_e;

  function automatic int unsigned clks_per_bit(
    input int unsigned f,
    input int unsigned b
  );
    return f / b;
  endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Byte stream from the bit FSM to the word FSM.
// master = byte receiver, slave = consumer.
interface uart_rx_word_if;

  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output byte_out,
    output byte_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input byte_out,
    input byte_valid,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser plus mid-bit sampling FSM.
// A stop bit sampled low parks the FSM in BREAK until the line idles.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CPB = 868
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rxd_i,
  uart_rx_word_if.master  rx_o
);

  localparam int unsigned   CW   = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          rxd_m_q;
  logic          rxd_s_q;
  bit_st_e       st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic [7:0]    byte_q;
  logic          bv_q;
  logic          fe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      rxd_m_q <= rxd_i;
      rxd_s_q <= rxd_m_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= B_IDLE;
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      byte_q <= '0;
      bv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      bv_q  <= 1'b0;
      fe_q  <= 1'b0;
      cnt_q <= cnt_q + ONE;
      unique case (st_q)
        B_IDLE: begin
          cnt_q <= '0;
          if (!rxd_s_q) st_q <= B_START;
        end
        B_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            st_q  <= rxd_s_q ? B_IDLE : B_DATA;
          end
        end
        B_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            sh_q  <= {rxd_s_q, sh_q[7:1]};
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) st_q <= B_STOP;
          end
        end
        B_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            if (rxd_s_q) begin
              byte_q <= sh_q;
              bv_q   <= 1'b1;
              st_q   <= B_IDLE;
            end else begin
              fe_q <= 1'b1;
              st_q <= B_BREAK;
            end
          end
        end
        B_BREAK: begin
          cnt_q <= '0;
          if (rxd_s_q) st_q <= B_IDLE;
        end
        default: st_q <= B_IDLE;
      endcase
    end
  end

  assign rx_o.byte_out   = byte_q;
  assign rx_o.byte_valid = bv_q;
  assign rx_o.frame_err  = fe_q;
  assign rx_o.busy       = (st_q != B_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// Serial sample receiver: pairs tagged high/low bytes into 12-bit words.
// High byte = {10, d[11:6]}, low byte = {00, d[5:0]}.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DATA_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rxd,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              sync_err,
  output logic              busy
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);

  uart_rx_word_if rx_if ();

  uart_rx_byte #(
    .CPB (CPB)
  ) u_byte (
    .clk   (clk),
    .rst_n (reset),
    .rxd_i (uart_rxd),
    .rx_o  (rx_if)
  );

  word_st_e          ws_q;
  logic [5:0]        hi6_q;
  logic [DATA_W-1:0] data_q;
  logic              dv_q;
  logic              se_q;

  logic [7:0] b;
  logic       tag_bad;
  logic       tag_hi;
  logic       tag_lo;

  assign b       = rx_if.byte_out;
  assign tag_bad = b[6];
  assign tag_hi  = (b[7:6] == TAG_HI);
  assign tag_lo  = (b[7:6] == TAG_LO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_q   <= W_HI;
      hi6_q  <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      se_q <= 1'b0;
      if (rx_if.frame_err) begin
        ws_q <= W_HI;
      end else if (rx_if.byte_valid) begin
        unique case (1'b1)
          tag_bad: begin
            se_q <= 1'b1;
            ws_q <= W_HI;
          end
          // a second high byte resyncs onto the newer half
          tag_hi: begin
            hi6_q <= b[5:0];
            se_q  <= (ws_q == W_LO);
            ws_q  <= W_LO;
          end
          tag_lo: begin
            if (ws_q == W_LO) begin
              data_q <= {hi6_q, b[5:0]};
              dv_q   <= 1'b1;
              ws_q   <= W_HI;
            end else begin
              se_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_out   = rx_if.byte_out;
  assign byte_valid = rx_if.byte_valid;
  assign frame_err  = rx_if.frame_err;
  assign busy       = rx_if.busy;
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign sync_err   = se_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word at 16 clocks per bit.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_uart_rx_word;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rxd = 1'b1;
  logic [11:0] data_out;
  logic        data_valid;
  logic        sync_err;

  uart_rx_word_if mon_if ();

  uart_rx_word #(
    .CLK_FREQ (100_000_000),
    .BAUD     (6_250_000),
    .DATA_W   (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rxd   (rxd),
    .byte_out   (mon_if.byte_out),
    .byte_valid (mon_if.byte_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (mon_if.frame_err),
    .sync_err   (sync_err),
    .busy       (mon_if.busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int test_id = 0;

  logic [7:0]  exp_b[$];
  logic [11:0] exp_w[$];
  int          exp_s[$];
  int          exp_f[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic unexp(input string name, input logic [31:0] v);
    total++;
    bad++;
    $display("FAIL %s: unexpected pulse value %0h required none", name, v);
  endtask

  always @(negedge clk) begin
    if (mon_if.byte_valid) begin
      if (exp_b.size() == 0) unexp("byte_valid", mon_if.byte_out);
      else chk("byte_out", mon_if.byte_out, exp_b.pop_front());
    end
    if (data_valid) begin
      if (exp_w.size() == 0) unexp("data_valid", data_out);
      else chk("data_out", data_out, exp_w.pop_front());
    end
    if (sync_err) begin
      if (exp_s.size() == 0) unexp("sync_err", test_id);
      else chk("sync_err_test", test_id, exp_s.pop_front());
    end
    if (mon_if.frame_err) begin
      if (exp_f.size() == 0) unexp("frame_err", test_id);
      else chk("frame_err_test", test_id, exp_f.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(CPB);
    end
    rxd = stop;
    cyc(CPB);
  endtask

  task automatic drain(input string name);
    cyc(40);
    chk(name, exp_b.size() + exp_w.size() + exp_s.size() + exp_f.size(), 0);
  endtask

  initial begin
    int n;
    logic [7:0] ab;
    ab = 8'hAA;
    cyc(3);
    #1;
    chk("rst_byte_out", mon_if.byte_out, 0);
    chk("rst_byte_valid", mon_if.byte_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_err", mon_if.frame_err, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_busy", mon_if.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(5);

    test_id = 1;
    exp_b.push_back(8'hAA);
    exp_b.push_back(8'h3C);
    exp_w.push_back(12'hABC);
    send(8'hAA, 1'b1);
    send(8'h3C, 1'b1);
    drain("t1_drain");

    test_id = 2;
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (mon_if.busy) n++;
    end
    chk("t2_busy_seen", n > 0, 1);
    chk("t2_busy_max", n <= 11, 1);
    chk("t2_busy_end", mon_if.busy, 0);
    drain("t2_drain");

    test_id = 3;
    exp_f.push_back(3);
    send(8'hAA, 1'b0);
    cyc(10);
    chk("t3_busy_low_a", mon_if.busy, 1);
    cyc(30);
    chk("t3_busy_low_b", mon_if.busy, 1);
    rxd = 1'b1;
    cyc(16);
    chk("t3_busy_idle", mon_if.busy, 0);
    exp_b.push_back(8'h3C);
    exp_s.push_back(3);
    send(8'h3C, 1'b1);
    drain("t3_drain");
    chk("t3_data_hold", data_out, 12'hABC);

    test_id = 4;
    exp_b.push_back(8'hAA);
    exp_b.push_back(8'h81);
    exp_s.push_back(4);
    exp_b.push_back(8'h05);
    exp_w.push_back(12'h045);
    send(8'hAA, 1'b1);
    send(8'h81, 1'b1);
    send(8'h05, 1'b1);
    drain("t4_drain");

    test_id = 5;
    exp_b.push_back(8'h40);
    exp_s.push_back(5);
    send(8'h40, 1'b1);
    cyc(20);
    exp_b.push_back(8'hBF);
    exp_b.push_back(8'h3F);
    exp_w.push_back(12'hFFF);
    send(8'hBF, 1'b1);
    send(8'h3F, 1'b1);
    drain("t5_drain");

    test_id = 6;
    rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = ab[i];
      cyc(CPB);
    end
    rxd = ab[4];
    cyc(8);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", mon_if.busy, 0);
    chk("t6_rst_byte_out", mon_if.byte_out, 0);
    chk("t6_rst_data_out", data_out, 0);
    rxd = 1'b1;
    cyc(4);
    reset = 1'b1;
    cyc(20);
    chk("t6_idle", mon_if.busy, 0);
    exp_b.push_back(8'h80);
    exp_b.push_back(8'h00);
    exp_w.push_back(12'h000);
    send(8'h80, 1'b1);
    send(8'h00, 1'b1);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
